// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Snoops an 8080-style parallel LCD bus driven by the display controller.
//   Decodes commands, tracks the CASET/PASET window and emits one pixel
//   event per RGB565 word received after RAMWR.  The pixel is reduced to
//   4:4:4 on the way out.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   lcd_db      bus data byte
//   lcd_wr      active-low write strobe; byte taken on its rising edge
//   lcd_d_c     0 = command, 1 = data/parameter
//   lcd_reset   active-low panel reset from the bus
//   cmd_valid   one-cycle pulse per command byte
//   cmd_code    last command byte (held)
//   pix_valid   one-cycle pulse per complete pixel
//   pix_x/pix_y coordinates qualified by pix_valid
//   pix_rgb     4:4:4 pixel colour
//   frame_done  pulse with the pixel written at (x_end, y_end)
//
// Decoder states
//   state | meaning
//   IDLE  | after reset, data bytes ignored
//   CASET | collecting 4 column-window bytes
//   PASET | collecting 4 row-window bytes
//   RAMWR | pixel stream, MSB/LSB pairs
//   SKIP  | unsupported command or finished window, data ignored
module lcd_bus_receiver #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                lcd_db,
  input  logic                      lcd_wr,
  input  logic                      lcd_d_c,
  input  logic                      lcd_reset,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_code,
  output logic                      pix_valid,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
  output logic [11:0]               pix_rgb,
  output logic                      frame_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [15:0] XMAX = 16'(WIDTH - 1);
  localparam logic [15:0] YMAX = 16'(HEIGHT - 1);
  // Idle bus image {rst_n, wr, d_c, db}: no panel reset, strobe high.
  localparam logic [10:0] BUS_IDLE = 11'h600;

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

  // ---------------------------------------------------------------------
  // Bus synchronizer: all bus lines move through the chain as one group.
  // ---------------------------------------------------------------------
  logic [10:0] sync_q [NS];
  logic        wr_dly_q;
  logic [10:0] bus_s;
  logic [7:0]  bus_db;
  logic        bus_dc;
  logic        strobe;
  logic        clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) sync_q[i] <= BUS_IDLE;
      wr_dly_q <= 1'b1;
    end else begin
      sync_q[0] <= {lcd_reset, lcd_wr, lcd_d_c, lcd_db};
      for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
      wr_dly_q <= sync_q[NS-1][9];
    end
  end

  assign bus_s  = sync_q[NS-1];
  assign bus_db = bus_s[7:0];
  assign bus_dc = bus_s[8];
  assign strobe = bus_s[9] & ~wr_dly_q;
  // The panel reset from the bus acts exactly like the local reset.
  assign clr    = reset | ~bus_s[10];

  // ---------------------------------------------------------------------
  // Window clamping for the 4th parameter byte.
  // ---------------------------------------------------------------------
  function automatic logic [15:0] clamp_lim(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [15:0] par_start_q;
  logic [7:0]  par_end_hi_q;
  logic [XW-1:0] x_lo_d, x_hi_raw, x_hi_d;
  logic [YW-1:0] y_lo_d, y_hi_raw, y_hi_d;

  always_comb begin
    x_lo_d   = XW'(clamp_lim(par_start_q, XMAX));
    x_hi_raw = XW'(clamp_lim({par_end_hi_q, bus_db}, XMAX));
    x_hi_d   = (x_hi_raw < x_lo_d) ? x_lo_d : x_hi_raw;
    y_lo_d   = YW'(clamp_lim(par_start_q, YMAX));
    y_hi_raw = YW'(clamp_lim({par_end_hi_q, bus_db}, YMAX));
    y_hi_d   = (y_hi_raw < y_lo_d) ? y_lo_d : y_hi_raw;
  end

  // ---------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------
  state_t        state_q;
  logic [1:0]    pcnt_q;
  logic          phase_q;
  logic [6:0]    msb_q;     // {R[15:12], G[10:8]}; R[11] is not needed
  logic [XW-1:0] x_start_q, x_end_q, cx_q;
  logic [YW-1:0] y_start_q, y_end_q, cy_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      pcnt_q       <= 2'd0;
      phase_q      <= 1'b0;
      msb_q        <= 7'd0;
      par_start_q  <= 16'd0;
      par_end_hi_q <= 8'd0;
      x_start_q    <= '0;
      x_end_q      <= XMAX[XW-1:0];
      y_start_q    <= '0;
      y_end_q      <= YMAX[YW-1:0];
      cx_q         <= '0;
      cy_q         <= '0;
      cmd_valid    <= 1'b0;
      cmd_code     <= 8'h00;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_rgb      <= 12'h000;
      frame_done   <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (strobe) begin
        if (!bus_dc) begin
          // Any command drops a pending parameter or half pixel.
          cmd_valid <= 1'b1;
          cmd_code  <= bus_db;
          pcnt_q    <= 2'd0;
          phase_q   <= 1'b0;
          case (bus_db)
            8'h2A:   state_q <= CASET;
            8'h2B:   state_q <= PASET;
            8'h2C: begin
              state_q <= RAMWR;
              cx_q    <= x_start_q;
              cy_q    <= y_start_q;
            end
            default: state_q <= SKIP;
          endcase
        end else begin
          case (state_q)
            CASET, PASET: begin
              pcnt_q <= pcnt_q + 2'd1;
              case (pcnt_q)
                2'd0: par_start_q[15:8] <= bus_db;
                2'd1: par_start_q[7:0]  <= bus_db;
                2'd2: par_end_hi_q      <= bus_db;
                default: begin
                  if (state_q == CASET) begin
                    x_start_q <= x_lo_d;
                    x_end_q   <= x_hi_d;
                  end else begin
                    y_start_q <= y_lo_d;
                    y_end_q   <= y_hi_d;
                  end
                  state_q <= SKIP;
                end
              endcase
            end
            RAMWR: begin
              if (!phase_q) begin
                msb_q   <= {bus_db[7:4], bus_db[2:0]};
                phase_q <= 1'b1;
              end else begin
                phase_q   <= 1'b0;
                pix_valid <= 1'b1;
                pix_x     <= cx_q;
                pix_y     <= cy_q;
                pix_rgb   <= {msb_q[6:3], msb_q[2:0], bus_db[7], bus_db[4:1]};
                if (cx_q == x_end_q) begin
                  cx_q <= x_start_q;
                  if (cy_q == y_end_q) begin
                    cy_q       <= y_start_q;
                    frame_done <= 1'b1;
                  end else begin
                    cy_q <= cy_q + YW'(1);
                  end
                end else begin
                  cx_q <= cx_q + XW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Testbench for lcd_bus_receiver: directed bus transactions followed by a
// randomized command/data stream, checked against a byte-level model of the
// panel protocol (window registers, cursor, pending-MSB queue).
module tb_lcd_bus_receiver;

  localparam int W = 320;
  localparam int H = 240;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lcd_db;
  logic       lcd_wr;
  logic       lcd_d_c;
  logic       lcd_reset;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       pix_valid;
  logic [$clog2(W)-1:0] pix_x;
  logic [$clog2(H)-1:0] pix_y;
  logic [11:0] pix_rgb;
  logic       frame_done;

  lcd_bus_receiver #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_db     (lcd_db),
    .lcd_wr     (lcd_wr),
    .lcd_d_c    (lcd_d_c),
    .lcd_reset  (lcd_reset),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
  int         m_cmd;            // last command, -1 when none since reset
  logic [7:0] m_code;
  logic [7:0] m_par[$];         // parameter bytes / pending pixel MSB

  task automatic model_reset();
    m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
    m_cx = 0; m_cy = 0;
    m_cmd = -1; m_code = 8'h00;
    m_par.delete();
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b,
                            output bit ec, output bit ep, output bit ef,
                            output int ex, output int ey, output int er);
    int lim, s, e;
    logic [15:0] w;
    ec = 0; ep = 0; ef = 0; ex = 0; ey = 0; er = 0;
    if (!dc) begin
      ec = 1;
      m_code = b;
      m_cmd = int'(b);
      m_par.delete();
      if (b == 8'h2C) begin
        m_cx = m_xs;
        m_cy = m_ys;
      end
    end else if ((m_cmd == 'h2A || m_cmd == 'h2B) && m_par.size() < 4) begin
      m_par.push_back(b);
      if (m_par.size() == 4) begin
        lim = (m_cmd == 'h2A) ? W - 1 : H - 1;
        s = int'({m_par[0], m_par[1]});
        e = int'({m_par[2], m_par[3]});
        if (s > lim) s = lim;
        if (e > lim) e = lim;
        if (e < s) e = s;
        if (m_cmd == 'h2A) begin m_xs = s; m_xe = e; end
        else begin m_ys = s; m_ye = e; end
      end
    end else if (m_cmd == 'h2C) begin
      if (m_par.size() == 0) begin
        m_par.push_back(b);
      end else begin
        w = {m_par[0], b};
        m_par.delete();
        ep = 1; ex = m_cx; ey = m_cy;
        er = int'({w[15:12], w[10:7], w[4:1]});
        if (m_cx == m_xe) begin
          m_cx = m_xs;
          if (m_cy == m_ye) begin m_cy = m_ys; ef = 1; end
          else m_cy = m_cy + 1;
        end else begin
          m_cx = m_cx + 1;
        end
      end
    end
  endtask

  // ---------------- bus driver + checks ----------------
  task automatic send_byte(input bit dc, input logic [7:0] b);
    bit ec, ep, ef;
    int ex, ey, er;
    model_byte(dc, b, ec, ep, ef, ex, ey, er);
    @(negedge clk);
    lcd_db = b; lcd_d_c = dc; lcd_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lcd_wr = 1'b1;
    for (int k = 1; k <= S + 3; k++) begin
      @(posedge clk); #1;
      if (k == S + 1) begin
        chk("cmd_valid", 32'(cmd_valid), 32'(ec));
        chk("pix_valid", 32'(pix_valid), 32'(ep));
        chk("frame_done", 32'(frame_done), 32'(ef));
        if (ec) chk("cmd_code", 32'(cmd_code), 32'(b));
        if (ep) begin
          chk("pix_x", 32'(pix_x), 32'(ex));
          chk("pix_y", 32'(pix_y), 32'(ey));
          chk("pix_rgb", 32'(pix_rgb), 32'(er));
        end
      end else begin
        chk("cmd_valid_off_slot", 32'(cmd_valid), 32'd0);
        chk("pix_valid_off_slot", 32'(pix_valid), 32'd0);
        chk("frame_done_off_slot", 32'(frame_done), 32'd0);
      end
    end
    chk("cmd_code_held", 32'(cmd_code), 32'(m_code));
  endtask

  task automatic send_pix(input logic [15:0] w);
    send_byte(1'b1, w[15:8]);
    send_byte(1'b1, w[7:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_cmd_code"}, 32'(cmd_code), 32'h00);
    chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'h000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_panel_reset();
    @(negedge clk);
    lcd_reset = 1'b0;
    repeat (4) @(negedge clk);
    lcd_reset = 1'b1;
    repeat (S + 2) @(negedge clk);
    model_reset();
    check_reset_outputs("panel_reset");
  endtask

  task automatic send_cmd_params(input logic [7:0] c, input logic [7:0] p0,
                                 input logic [7:0] p1, input logic [7:0] p2,
                                 input logic [7:0] p3);
    send_byte(1'b0, c);
    send_byte(1'b1, p0);
    send_byte(1'b1, p1);
    send_byte(1'b1, p2);
    send_byte(1'b1, p3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; lcd_db = 8'h00; lcd_wr = 1'b1; lcd_d_c = 1'b0; lcd_reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    @(negedge clk);
    reset = 1'b0;

    // First pixel after reset: full window, cursor at origin.
    send_byte(1'b0, 8'h2C);
    send_pix(16'hF800);

    // Small 2x2 window, wrap and frame_done.
    send_cmd_params(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B);
    send_cmd_params(8'h2B, 8'h00, 8'h05, 8'h00, 8'h06);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) send_pix(16'($urandom()));

    // Column window out of range with end < start.
    send_cmd_params(8'h2A, 8'h01, 8'hFF, 8'h00, 8'h00);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 3; i++) send_pix(16'($urandom()));

    // Half pixel abandoned by a new command; data after it ignored.
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h07);
    send_byte(1'b0, 8'h29);
    send_byte(1'b1, 8'hE0);

    // Truncated CASET must not touch the window.
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h03);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 2; i++) send_pix(16'($urandom()));

    // Reset during CASET.
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h05);
    do_reset();
    send_byte(1'b1, 8'h55);
    send_byte(1'b0, 8'h2C);
    send_pix(16'h001F);

    // Panel reset from the bus in the middle of a pixel stream.
    send_cmd_params(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B);
    send_byte(1'b0, 8'h2C);
    send_pix(16'h1234);
    send_byte(1'b1, 8'hAB);
    do_panel_reset();
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 3; i++) send_pix(16'($urandom()));

    // Randomized command/data stream.
    for (int it = 0; it < 40; it++) begin
      int sel;
      int nb;
      logic [7:0] c;
      logic [7:0] d;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    c = 8'h2A;
        2, 3:    c = 8'h2B;
        4, 5, 6: c = 8'h2C;
        7:       c = 8'h29;
        default: c = 8'($urandom());
      endcase
      if (sel == 9 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) do_reset();
        else do_panel_reset();
      end
      send_byte(1'b0, c);
      nb = $urandom_range(0, 9);
      for (int j = 0; j < nb; j++) begin
        if ((m_cmd == 'h2A || m_cmd == 'h2B) && (m_par.size() % 2 == 0))
          d = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 1));
        else
          d = 8'($urandom());
        send_byte(1'b1, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 Parameter WIDTH, default 320, LCD panel width in pixels.
REQ-002 Parameter HEIGHT, default 240, LCD panel height in pixels.
REQ-003 Parameter SYNC_STAGES, default 2, number of synchronizer flops on the bus inputs (minimum 2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 lcd_db  input  8  8080-style parallel data bus driven by Screens_dispaly.
REQ-007 lcd_wr  input  1  active-low write strobe; a byte is transferred on its rising edge.
REQ-008 lcd_d_c  input  1  0 = command byte, 1 = data/parameter byte.
REQ-009 lcd_reset  input  1  active-low panel reset from the bus.
REQ-010 cmd_valid  output  1  one-cycle pulse per command byte received.
REQ-011 cmd_code  output  8  last command byte; valid with cmd_valid, held afterwards.
REQ-012 pix_valid  output  1  one-cycle pulse per complete RGB565 pixel.
REQ-013 pix_x  output  $clog2(WIDTH)  column of the pixel qualified by pix_valid.
REQ-014 pix_y  output  $clog2(HEIGHT)  row of the pixel qualified by pix_valid.
REQ-015 pix_rgb  output  12  pixel as 4:4:4 (R[15:12], G[10:7], B[4:1] of the RGB565 word).
REQ-016 frame_done  output  1  one-cycle pulse, coincident with pix_valid, when the pixel at (x_end, y_end) is written.

Function
REQ-017 lcd_db, lcd_d_c, lcd_wr, and lcd_reset SHALL pass through SYNC_STAGES flops as a group, plus one more flop on lcd_wr for edge detection.
- Byte strobe: synchronized wr = 1 and its delayed copy = 0.
- Data and d_c are taken from the synchronized copy.
REQ-018 Outputs SHALL be registered; each pulse asserts on the clock edge after the byte strobe, i.e. SYNC_STAGES+1 edges after lcd_wr is first sampled high.
REQ-019 The decoder FSM SHALL use states IDLE, CASET, PASET, RAMWR, SKIP; any command byte (d_c=0) SHALL pulse cmd_valid, load cmd_code, and clear the parameter byte counter.
REQ-020 On a command byte, the next state SHALL be:
- 0x2A -> CASET
- 0x2B -> PASET
- 0x2C -> RAMWR, with cursor loaded to (x_start, y_start) and pixel byte phase cleared
- any other code -> SKIP
REQ-021 In CASET, 4 data bytes SHALL form x_start[15:8], x_start[7:0], x_end[15:8], x_end[7:0]; after the 4th byte the FSM SHALL go to SKIP; PASET does the same for y_start and y_end.
REQ-022 Window values SHALL be applied after the 4th byte only:
- Values >= WIDTH (or HEIGHT) clamp to WIDTH-1 (or HEIGHT-1).
- If the clamped end < the clamped start, end = start.
- A window command cut short by a new command SHALL leave the previous window unchanged.
REQ-023 In RAMWR, even bytes SHALL be the RGB565 MSB and odd bytes the LSB; the LSB SHALL pulse pix_valid with the current cursor.
REQ-024 Cursor advance after each pixel:
- If x = x_end: x = x_start and y increments.
- If y was also y_end: y = y_start, with frame_done pulsed for that pixel.
- Otherwise x increments.
REQ-025 Data bytes in IDLE or SKIP SHALL be ignored with no output pulse.
REQ-026 A command byte arriving between RAMWR MSB and LSB SHALL drop the half pixel, with no pix_valid.

Reset
REQ-027 reset=1, or synchronized lcd_reset=0, SHALL on the next edge set:
- FSM = IDLE; cmd_valid = pix_valid = frame_done = 0
- cmd_code = 0x00; pix_x = pix_y = 0; pix_rgb = 0x000
- window = (0, WIDTH-1, 0, HEIGHT-1); cursor = (0, 0); byte phase and parameter counter cleared
REQ-028 Reset mid-transfer SHALL abandon any partial parameter or pixel; the first byte after release SHALL be decoded from IDLE.
REQ-029 reset SHALL take priority over a simultaneous byte strobe.

Verification
REQ-030 Write 0x2C, then bytes F8,00 -> cmd_valid with cmd_code=0x2C; then pix_valid with x=0, y=0, rgb=0xF00, exactly SYNC_STAGES+1 edges after the LSB wr rising edge.
REQ-031 Send 2A:00,0A,00,0B; 2B:00,05,00,06; 2C, then 4 pixels -> coordinates (10,5), (11,5), (10,6), (11,6); frame_done only on (11,6); a 5th pixel -> (10,5).
REQ-032 Send 2A:01,FF,00,00 (x_start=511, x_end=0) -> window clamps to x_start=x_end=319; every pixel after 2C has x=319.
REQ-033 Send 2C, byte 07, then command 0x29, then data E0 -> cmd_valid for 0x29; no pix_valid; byte E0 ignored.
REQ-034 Assert reset during CASET after 2 bytes -> outputs go to the REQ-027 values; then send 2C, 00,1F -> pixel (0,0) with rgb=0x00F.
REQ-035 Drive lcd_reset=0 for 4 cycles in the middle of a RAMWR stream -> window restored to full screen; no pix_valid until a new 0x2C is received.
